// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: scanout reads have priority, and a
// starvation counter forces a cpu access through after STARVE_MAX lost conflicts.
module fb_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 18,
  parameter int STARVE_MAX = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              vid_stall,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_wenable,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       vid_rvalid_q, vid_rvalid_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       vid_stall_q, vid_stall_d;
  logic       grant_vid, grant_cpu;

  always_comb begin
    grant_vid    = 1'b0;
    grant_cpu    = 1'b0;
    bram_addr    = '0;
    bram_wdata   = '0;
    bram_wenable = 1'b0;
    if (!reset) begin
      if (vid_req && cpu_req) begin
        grant_cpu = (starve_cnt_q == STARVE_LIM);
        grant_vid = !grant_cpu;
      end else begin
        grant_vid = vid_req;
        grant_cpu = cpu_req;
      end
    end
    if (grant_vid) begin
      bram_addr = vid_addr;
    end else if (grant_cpu) begin
      bram_addr    = cpu_addr;
      bram_wdata   = cpu_wdata;
      bram_wenable = cpu_we;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || grant_cpu) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    vid_rvalid_d = grant_vid;
    cpu_rvalid_d = grant_cpu && !cpu_we;
    vid_stall_d  = vid_stall_q || (vid_req && !grant_vid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_stall_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_stall_q  <= vid_stall_d;
    end
  end

  // Read valids are masked while reset is high so an access acked just
  // before reset never surfaces a stray rvalid.
  assign vid_ack    = grant_vid;
  assign cpu_ack    = grant_cpu;
  assign vid_rvalid = vid_rvalid_q && !reset;
  assign cpu_rvalid = cpu_rvalid_q && !reset;
  assign vid_rdata  = bram_rdata;
  assign cpu_rdata  = bram_rdata;
  assign vid_stall  = vid_stall_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized bench for fb_port_arbiter: a BRAM model plus a cycle-level
// reference of grants, read returns, stall flag and cpu wait length.
module tb_fb_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 18;
  localparam int SM = 3;

  logic          clock;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          vid_rvalid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          vid_stall;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic          bram_wenable;
  logic [DW-1:0] bram_rdata;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .vid_stall(vid_stall),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_wenable(bram_wenable), .bram_rdata(bram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bram_wenable) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic          known  [0:(1<<AW)-1];
  int unsigned   m_wait = 0;
  int unsigned   dut_wait = 0;
  logic          m_stall = 1'b0;
  logic          m_vpend = 1'b0, m_cpend = 1'b0;
  logic          m_vknown = 1'b0, m_cknown = 1'b0;
  logic [DW-1:0] m_vdata = '0, m_cdata = '0;
  logic          last_vack, last_cack;

  task automatic step(input logic r, input logic vr, input logic [AW-1:0] va,
                      input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd);
    logic          ev, ec;
    logic [AW-1:0] ea;
    reset = r; vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ev = 1'b0; ec = 1'b0;
    if (!r) begin
      if (vr && cr) begin
        ec = (m_wait == SM);
        ev = !ec;
      end else begin
        ev = vr;
        ec = cr;
      end
    end
    @(negedge clock);
    chk("vid_ack", vid_ack, ev);
    chk("cpu_ack", cpu_ack, ec);
    chk("one_ack", vid_ack & cpu_ack, 0);
    chk("bram_we", bram_wenable, ec && cw);
    if (!r) begin
      ea = ev ? va : (ec ? ca : '0);
      chk("bram_addr", bram_addr, ea);
      if (!ev) chk("bram_wdata", bram_wdata, ec ? cd : '0);
    end
    chk("vid_rvalid", vid_rvalid, m_vpend && !r);
    chk("cpu_rvalid", cpu_rvalid, m_cpend && !r);
    if (m_vpend && !r && m_vknown) chk("vid_rdata", vid_rdata, m_vdata);
    if (m_cpend && !r && m_cknown) chk("cpu_rdata", cpu_rdata, m_cdata);
    chk("vid_stall", vid_stall, m_stall);
    if (cr && !r) chk("cpu_wait", dut_wait <= SM, 1);
    last_vack = vid_ack;
    last_cack = cpu_ack;
    m_vpend = ev;
    if (ev) begin m_vknown = known[va]; m_vdata = shadow[va]; end
    m_cpend = ec && !cw;
    if (ec && !cw) begin m_cknown = known[ca]; m_cdata = shadow[ca]; end
    if (ec && cw) begin shadow[ca] = cd; known[ca] = 1'b1; end
    m_stall  = r ? 1'b0 : (m_stall || (vr && !ev));
    m_wait   = (r || !cr || ec) ? 0 : ((m_wait < SM) ? m_wait + 1 : m_wait);
    dut_wait = (r || !cr || cpu_ack) ? 0 : dut_wait + 1;
    @(posedge clock); #1;
  endtask

  logic [7:0]    seq8;
  logic [3:0]    seq4;
  logic          pv, pc, pcw;
  logic [AW-1:0] pva, pca;
  logic [DW-1:0] pcd;

  initial begin
    for (int i = 0; i < (1 << AW); i++) known[i] = 1'b0;
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    step(1, 0, '0, 0, 0, '0, '0);
    step(0, 0, '0, 0, 0, '0, '0);

    for (int i = 0; i < 16; i++) step(0, 0, '0, 1, 1, AW'(i), DW'($urandom));
    step(0, 0, '0, 1, 1, 14'h0100, 18'h00ABC);
    step(0, 0, '0, 1, 1, 14'h0010, 18'h3F000);
    chk("w038_no_rvalid", cpu_rvalid, 0);

    step(0, 1, 14'h0100, 0, 0, '0, '0);
    chk("r039_rvalid", vid_rvalid, 1);
    chk("r039_rdata", vid_rdata, 18'h00ABC);

    step(1, 0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 14'h0005, 1, 0, 14'h0003, '0);
      seq8[i] = last_cack;
    end
    chk("r040_cpu_seq", seq8, 8'h88);
    chk("r040_stall", vid_stall, 1);

    step(0, 1, 14'h0002, 1, 0, 14'h0004, '0);
    step(0, 1, 14'h0002, 1, 0, 14'h0004, '0);
    step(0, 1, 14'h0002, 0, 0, 14'h0004, '0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 14'h0002, 1, 0, 14'h0004, '0);
      seq4[i] = last_cack;
    end
    chk("r041_cpu_seq", seq4, 4'b1000);

    step(0, 1, 14'h0100, 0, 0, '0, '0);
    step(1, 1, 14'h0100, 1, 0, 14'h0001, '0);
    step(0, 0, '0, 0, 0, '0, '0);
    chk("r042_stall", vid_stall, 0);

    pv = 1'b0; pc = 1'b0; pcw = 1'b0; pva = '0; pca = '0; pcd = '0;
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, pv, pva, pc, pcw, pca, pcd);
      if (!pv || last_vack) begin
        pv  = $urandom_range(0, 2) != 0;
        pva = ($urandom_range(0, 7) == 0) ? 14'h0100 : AW'($urandom_range(0, 15));
      end
      if (!pc || last_cack) begin
        pc  = $urandom_range(0, 3) != 0;
        pcw = $urandom_range(0, 1) != 0;
        pca = AW'($urandom_range(0, 15));
        pcd = DW'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, framebuffer word address width.
REQ-002 Parameter DATA_W, default 18, pixel word width (3 x 6-bit RGB).
REQ-003 Parameter STARVE_MAX, default 15, consecutive video-won conflict cycles before the cpu port is forced through (range 1..255).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, exposed as the ports below.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 vid_req  in  1  scanout read request.
REQ-008 vid_addr  in  ADDR_W  scanout read address.
REQ-009 vid_ack  out  1  scanout access issued this cycle.
REQ-010 vid_rdata  out  DATA_W  scanout read data, qualified by vid_rvalid.
REQ-011 vid_rvalid  out  1  vid_rdata valid.
REQ-012 cpu_req  in  1  cpu access request.
REQ-013 cpu_we  in  1  1 = write, 0 = read.
REQ-014 cpu_addr  in  ADDR_W  cpu address.
REQ-015 cpu_wdata  in  DATA_W  cpu write data.
REQ-016 cpu_ack  out  1  cpu access issued this cycle.
REQ-017 cpu_rdata  out  DATA_W  cpu read data, qualified by cpu_rvalid.
REQ-018 cpu_rvalid  out  1  cpu_rdata valid.
REQ-019 vid_stall  out  1  sticky flag: a video request was denied at least once.
REQ-020 bram_addr  out  ADDR_W  single-port BRAM address.
REQ-021 bram_wdata  out  DATA_W  BRAM write data.
REQ-022 bram_wenable  out  1  BRAM write enable.
REQ-023 bram_rdata  in  DATA_W  BRAM read data, valid one cycle after the addressed cycle.

Function
REQ-024 Grants SHALL be combinational per cycle; at most one of vid_ack/cpu_ack SHALL be 1 in any cycle.
REQ-025 Neither req: no ack, bram_addr = 0, bram_wenable = 0, bram_wdata = 0.
REQ-026 Exactly one req: that requester is acked the same cycle.
REQ-027 Both req: cpu acked iff starve_cnt == STARVE_MAX, otherwise video acked.
REQ-028 starve_cnt (8-bit internal): +1 on cycles with cpu_req=1 and cpu_ack=0, saturating at STARVE_MAX; cleared to 0 on any cycle with cpu_ack=1 or cpu_req=0.
REQ-029 vid_ack: bram_addr = vid_addr, bram_wenable = 0.
REQ-030 cpu_ack: bram_addr = cpu_addr, bram_wenable = cpu_we, bram_wdata = cpu_wdata.
REQ-031 vid_rvalid SHALL be vid_ack registered by one cycle; cpu_rvalid SHALL be (cpu_ack and not cpu_we) registered by one cycle; both rdata outputs pass bram_rdata through.
REQ-032 Requesters hold req/addr/wdata stable until ack; each ack consumes exactly one access; req held after ack is a new request (back-to-back accesses at one per cycle allowed).
REQ-033 vid_stall SHALL set on the edge after any cycle with vid_req=1 and vid_ack=0, and remain set until reset.
REQ-034 Cpu write latency is zero cycles (ack cycle = BRAM write); read latency is one cycle (ack -> rvalid).

Reset
REQ-035 While reset=1: vid_ack = cpu_ack = 0 and bram_wenable = 0 regardless of requests.
REQ-036 At a clock edge with reset=1: starve_cnt = 0, vid_rvalid = 0, cpu_rvalid = 0, vid_stall = 0; a read acked in the cycle before reset produces no rvalid.
REQ-037 First cycle after reset deasserts: normal arbitration with starve_cnt = 0.

Verification
REQ-038 Only cpu_req (we=1, addr=0x0010, wdata=0x3F000) -> cpu_ack=1 and bram_wenable=1 same cycle, bram_addr=0x0010; no cpu_rvalid next cycle.
REQ-039 Only vid_req (addr=0x0100), BRAM holds 0x00ABC -> vid_ack same cycle, next cycle vid_rvalid=1, vid_rdata=0x00ABC.
REQ-040 STARVE_MAX=3, vid_req and cpu_req (read) held continuously -> video acked cycles 0-2, cpu acked cycle 3, video cycles 4-6, cpu cycle 7; vid_stall=1 from cycle 4; cpu_rvalid in cycles 4 and 8.
REQ-041 Both req, cpu_req dropped at starve_cnt=2 and reasserted -> counter restarts at 0; cpu not granted until 3 further conflict cycles.
REQ-042 Reset asserted the cycle after a vid_ack -> vid_rvalid=0 at that edge, no acks during reset, vid_stall=0, starve_cnt=0 afterwards.
REQ-043 Random bench: never both acks, every read ack yields exactly one rvalid one cycle later, cpu waits never exceed STARVE_MAX+1 cycles.
